// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART frame controller: FSM states, default
// header byte and the running checksum step.
package uart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_HOLD
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  function automatic logic [7:0] cksum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one combinational read
// port. No reset; contents are only meaningful below the held frame length.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame assembler between the UART byte receiver and the command decoder:
// HDR, LEN, payload, 8-bit additive checksum, then held until acknowledged.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rx_en,
  input  logic                       rx_done,
  input  logic [7:0]                 rx_byte,
  output logic                       frm_valid,
  input  logic                       frm_ack,
  output logic [7:0]                 frm_len,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       err_cksum,
  output logic                       err_len,
  output logic                       err_timeout
);

  localparam int              AW       = $clog2(MAX_LEN);
  localparam int              TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_B    = 8'(MAX_LEN);

  state_e         state, state_n;
  logic           rx_done_q, byte_stb;
  logic [7:0]     len, len_n, idx, idx_n, sum, sum_n, frm_len_n;
  logic [TW-1:0]  tcnt, tcnt_n;
  logic           active, tmo, buf_we;
  logic           e_len_n, e_cksum_n, e_tmo_n;
  logic [7:0]     buf_rdata;

  // Strobes arriving in HOLD belong to a byte the receiver had in flight; drop them.
  assign byte_stb  = rx_done_q;
  assign frm_valid = (state == ST_HOLD);
  assign active    = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CKSUM);
  assign tmo       = active && !byte_stb && (tcnt == TMO_LAST);

  always_comb begin
    state_n   = state;
    len_n     = len;
    idx_n     = idx;
    sum_n     = sum;
    frm_len_n = frm_len;
    buf_we    = 1'b0;
    e_len_n   = 1'b0;
    e_cksum_n = 1'b0;
    e_tmo_n   = 1'b0;
    case (state)
      ST_IDLE: if (byte_stb && rx_byte == HDR_BYTE) state_n = ST_LEN;
      ST_LEN: if (byte_stb) begin
        if (rx_byte == 8'd0 || rx_byte > MAX_B) begin
          e_len_n = 1'b1;
          state_n = ST_IDLE;
        end else begin
          len_n   = rx_byte;
          idx_n   = 8'd0;
          sum_n   = rx_byte;
          state_n = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (byte_stb) begin
        buf_we = 1'b1;
        sum_n  = cksum_add(sum, rx_byte);
        idx_n  = idx + 8'd1;
        if (idx == len - 8'd1) state_n = ST_CKSUM;
      end
      ST_CKSUM: if (byte_stb) begin
        if (rx_byte == sum) begin
          frm_len_n = len;
          state_n   = ST_HOLD;
        end else begin
          e_cksum_n = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_HOLD: if (frm_ack) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // tmo already excludes byte_stb, so a byte landing on expiry wins.
    if (tmo) begin
      e_tmo_n = 1'b1;
      state_n = ST_IDLE;
    end
    tcnt_n = (!active || byte_stb || state_n != state) ? '0 : tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rx_done_q   <= 1'b0;
      rx_en       <= 1'b0;
      len         <= '0;
      idx         <= '0;
      sum         <= '0;
      tcnt        <= '0;
      frm_len     <= '0;
      err_len     <= 1'b0;
      err_cksum   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      rx_done_q   <= rx_done && (state != ST_HOLD);
      rx_en       <= (state_n != ST_HOLD);
      len         <= len_n;
      idx         <= idx_n;
      sum         <= sum_n;
      tcnt        <= tcnt_n;
      frm_len     <= frm_len_n;
      err_len     <= e_len_n;
      err_cksum   <= e_cksum_n;
      err_timeout <= e_tmo_n;
    end
  end

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx[AW-1:0]),
    .wdata (rx_byte),
    .raddr (rd_addr),
    .rdata (buf_rdata)
  );

  assign rd_data = (8'(rd_addr) < frm_len) ? buf_rdata : 8'd0;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames from the test plan plus
// random frames, checked against a byte-stream frame parser model.
module tb_uart_rx_frame_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 40;
  localparam logic [7:0] HDR     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, rx_en, rx_done, frm_valid, frm_ack;
  logic       err_cksum, err_len, err_timeout;
  logic [7:0] rx_byte, frm_len, rd_data;
  logic [3:0] rd_addr;

  int errors = 0;
  int checks = 0;
  int n_len = 0, n_ck = 0, n_to = 0;
  logic excl_bad = 1'b0;
  logic fv_prev  = 1'b0;

  logic [7:0] stim[$];
  logic [7:0] exp_pl[256];

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.HDR_BYTE(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx_done(rx_done), .rx_byte(rx_byte),
    .frm_valid(frm_valid), .frm_ack(frm_ack), .frm_len(frm_len),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .err_cksum(err_cksum), .err_len(err_len), .err_timeout(err_timeout)
  );

  // Pulse counters and exclusivity watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_len) n_len++;
    if (err_cksum) n_ck++;
    if (err_timeout) n_to++;
    if (int'(err_len) + int'(err_cksum) + int'(err_timeout) > 1) excl_bad = 1'b1;
    if ((err_len || err_cksum || err_timeout) && frm_valid && !fv_prev) excl_bad = 1'b1;
    fv_prev = frm_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic v_mid);
    rx_byte = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    v_mid = frm_valid;
    @(posedge clk); #1;
  endtask

  // kind: 0 incomplete/nothing, 1 accepted, 2 length error, 3 checksum error
  task automatic model(output int kind, output int L);
    int i, s;
    kind = 0; L = 0; i = 0;
    while (i < stim.size() && stim[i] != HDR) i++;
    if (i + 1 >= stim.size()) return;
    L = int'(stim[i+1]);
    if (L == 0 || L > MAX_LEN) begin kind = 2; return; end
    if (i + 2 + L >= stim.size()) return;
    s = L;
    for (int j = 0; j < L; j++) begin
      exp_pl[j] = stim[i+2+j];
      s += int'(stim[i+2+j]);
    end
    kind = ((s % 256) == int'(stim[i+2+L])) ? 1 : 3;
  endtask

  task automatic do_ack(input string tag);
    frm_ack = 1'b1;
    @(posedge clk); #1;
    frm_ack = 1'b0;
    chk({tag, "/ack_valid"}, frm_valid, 0);
    chk({tag, "/ack_rx_en"}, rx_en, 1);
  endtask

  task automatic run_stim(input string tag, input bit hold_it);
    int k, L, b_len, b_ck, b_to;
    logic vm;
    model(k, L);
    b_len = n_len; b_ck = n_ck; b_to = n_to;
    vm = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], vm);
      if (i != stim.size() - 1) begin repeat (2) @(posedge clk); #1; end
    end
    if (k == 1) chk({tag, "/valid_early"}, vm, 0);
    chk({tag, "/valid"}, frm_valid, (k == 1));
    @(posedge clk); #1;
    chk({tag, "/err_len"}, n_len - b_len, (k == 2));
    chk({tag, "/err_cksum"}, n_ck - b_ck, (k == 3));
    chk({tag, "/err_timeout"}, n_to - b_to, 0);
    if (k == 1) begin
      chk({tag, "/frm_len"}, frm_len, L);
      chk({tag, "/rx_en_hold"}, rx_en, 0);
      for (int a = 0; a < L; a++) begin
        rd_addr = 4'(a); #1;
        chk($sformatf("%s/rd%0d", tag, a), rd_data, exp_pl[a]);
      end
      if (L < MAX_LEN) begin
        rd_addr = 4'(L); #1;
        chk({tag, "/rd_oob"}, rd_data, 0);
      end
      if (!hold_it) do_ack(tag);
    end
  endtask

  initial begin
    int b_to, b_all, typ, L, s;
    logic vm;
    logic [7:0] b;
    rst = 1'b1; rx_done = 1'b0; rx_byte = 8'h00; frm_ack = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst/rx_en", rx_en, 0);
    chk("rst/valid", frm_valid, 0);
    chk("rst/frm_len", frm_len, 0);
    chk("rst/errs", {err_len, err_cksum, err_timeout}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst/rx_en_up", rx_en, 1);

    // good frame, held while a stray in-flight byte arrives
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    run_stim("good", 1'b1);
    send_byte(8'hA5, vm);
    repeat (2) @(posedge clk); #1;
    chk("hold/valid", frm_valid, 1);
    chk("hold/frm_len", frm_len, 3);
    do_ack("hold");

    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    run_stim("badck", 1'b0);
    stim = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    run_stim("after_badck", 1'b0);

    stim = '{8'hA5, 8'h00};
    run_stim("len0", 1'b0);
    stim = '{8'hA5, 8'h11};
    run_stim("len17", 1'b0);
    stim = '{8'hA5, 8'h10};
    s = 16;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom); stim.push_back(b); s += int'(b);
    end
    stim.push_back(8'(s));
    run_stim("len16", 1'b0);

    // inter-byte timeout
    stim = '{8'hA5, 8'h02, 8'h44};
    b_to = n_to;
    run_stim("tmo_pre", 1'b0);
    repeat (TMO - 3) @(posedge clk); #1;
    chk("tmo/not_early", n_to - b_to, 0);
    for (int c = 0; c < 10 && n_to == b_to; c++) begin @(posedge clk); #1; end
    chk("tmo/fired", n_to - b_to, 1);
    stim = '{8'h44};
    run_stim("tmo_stray", 1'b0);
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
    run_stim("junk_embhdr", 1'b0);

    // reset mid-frame
    stim = '{8'hA5, 8'h04, 8'h01};
    run_stim("rst_pre", 1'b0);
    b_all = n_len + n_ck + n_to;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst/rx_en", rx_en, 0);
    chk("midrst/valid", frm_valid, 0);
    chk("midrst/frm_len", frm_len, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst/rx_en_up", rx_en, 1);
    chk("midrst/no_err", n_len + n_ck + n_to - b_all, 0);
    stim = '{8'hA5, 8'h01, 8'h05, 8'h06};
    run_stim("after_rst", 1'b0);

    // ack outside HOLD must be ignored
    frm_ack = 1'b1; @(posedge clk); #1; frm_ack = 1'b0;
    chk("idle_ack/valid", frm_valid, 0);

    for (int r = 0; r < 10; r++) begin
      stim.delete();
      typ = int'($urandom_range(0, 3));
      if (typ == 3) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom);
          if (b == HDR) b = 8'h00;
          stim.push_back(b);
        end
      end
      stim.push_back(HDR);
      L = int'($urandom_range(1, MAX_LEN));
      if (typ == 2) L = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      stim.push_back(8'(L));
      if (typ != 2) begin
        s = L;
        for (int i = 0; i < L; i++) begin
          b = 8'($urandom); stim.push_back(b); s += int'(b);
        end
        b = 8'(s);
        if (typ == 1) b = b ^ 8'($urandom_range(1, 255));
        stim.push_back(b);
      end
      run_stim($sformatf("rnd%0d_t%0d", r, typ), 1'b0);
    end

    chk("exclusive_pulses", excl_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
